// File: rtl/string_led_sequencer_if.sv
// SRAM port-1 (read-only) interface between the LED sequencer and the pixel
// buffer. The master issues cs_n/addr. The slave returns rdata in the cycle
// after it samples cs_n low.
interface string_led_sequencer_if #(
    parameter int ASIZE = 32
);
    logic             cs_n;
    logic [ASIZE-1:0] addr;
    logic [7:0]       rdata;

    modport master (output cs_n, output addr, input rdata);
    modport slave  (input cs_n, input addr, output rdata);
endinterface

// File: rtl/string_led_sequencer.sv
// String-LED serializer. It reads pixel bytes from the buffer SRAM and emits
// WS2812-style bit cells of 3 ticks each: "100" encodes a 0 and "110" encodes
// a 1. The byte window is replayed w_count times. A latch period of
// RESET_TICKS idle ticks follows the last pass.
// Optional build macro STRING_LED_LSB_FIRST_EN sends each byte LSB first.
// Without it, bytes are sent MSB first.
module string_led_sequencer #(
    parameter int ASIZE       = 32,
    parameter int PSIZE       = 32,
    parameter int RESET_TICKS = 80
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   controller_en,
    input  logic [PSIZE-1:0]       prescaler,
    input  logic                   polarity,
    input  logic [3:0]             w_count,
    input  logic [ASIZE-1:0]       w_first,
    input  logic [ASIZE-1:0]       w_last,
    input  logic                   start,
    output logic                   progress,
    string_led_sequencer_if.master mem,
    output logic                   dout
);

    localparam int LATCH_W = (RESET_TICKS > 1) ? $clog2(RESET_TICKS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH
    } state_t;

    state_t             r_state;
    logic [PSIZE-1:0]   r_tick_cnt;
    logic [ASIZE-1:0]   r_first;
    logic [ASIZE-1:0]   r_last;
    logic [ASIZE-1:0]   r_addr;
    logic [3:0]         r_pass;
    logic [7:0]         r_shift;
    logic [7:0]         r_prefetch;
    logic [2:0]         r_bit_cnt;     // bits still to send after the current one
    logic [1:0]         r_phase;
    logic               r_raw;         // line level before polarity inversion
    logic               r_cs_n;
    logic               r_progress;
    logic               r_pf_wait;     // prefetch read issued, data arrives next cycle
    logic               r_more;        // another byte follows the current one
    logic [LATCH_W-1:0] r_latch_cnt;

    logic               w_tick;
    logic               w_cur_bit;
    logic [7:0]         w_shifted;
    logic               w_final_byte;
    logic [ASIZE-1:0]   w_next_addr;

    // The tick counter restarts on every entry to a transfer.
    // Using >= means a prescaler lowered on the fly takes effect at once,
    // instead of the counter running on until it wraps.
    assign w_tick = (r_state != ST_IDLE) && (r_tick_cnt >= prescaler);

`ifdef STRING_LED_LSB_FIRST_EN
    assign w_cur_bit = r_shift[0];
    assign w_shifted = {1'b0, r_shift[7:1]};
`else
    assign w_cur_bit = r_shift[7];
    assign w_shifted = {r_shift[6:0], 1'b0};
`endif

    // The current byte ends the window. If it is also in the final pass,
    // nothing more is fetched.
    assign w_final_byte = (r_addr == r_last) && (r_pass == 4'd1);
    assign w_next_addr  = (r_addr == r_last) ? r_first : r_addr + ASIZE'(1);

    // Free-running tick divider, active only while a transfer is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (r_state == ST_IDLE || !controller_en || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + PSIZE'(1);
        end
    end

    // Transfer FSM: fetch, serialize with one-byte prefetch, then latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_first     <= '0;
            r_last      <= '0;
            r_addr      <= '0;
            r_pass      <= '0;
            r_shift     <= '0;
            r_prefetch  <= '0;
            r_bit_cnt   <= '0;
            r_phase     <= '0;
            r_raw       <= 1'b0;
            r_cs_n      <= 1'b1;
            r_progress  <= 1'b0;
            r_pf_wait   <= 1'b0;
            r_more      <= 1'b0;
            r_latch_cnt <= '0;
        end else if (r_state != ST_IDLE && !controller_en) begin
            // Abort: drop straight to idle with no latch period.
            r_state    <= ST_IDLE;
            r_progress <= 1'b0;
            r_cs_n     <= 1'b1;
            r_raw      <= 1'b0;
            r_pf_wait  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cs_n <= 1'b1;
                    r_raw  <= 1'b0;
                    if (start && controller_en && (w_count != 4'd0)) begin
                        r_first    <= w_first;
                        r_last     <= w_last;
                        r_pass     <= w_count;
                        r_addr     <= w_first;
                        r_cs_n     <= 1'b0;
                        r_progress <= 1'b1;
                        r_state    <= ST_READ;
                    end
                end

                ST_READ: begin
                    r_cs_n  <= 1'b1;
                    r_state <= ST_LOAD;
                end

                ST_LOAD: begin
                    r_shift   <= mem.rdata;
                    r_bit_cnt <= 3'd7;
                    r_phase   <= 2'd0;
                    r_raw     <= 1'b1;
                    r_state   <= ST_SHIFT;
                end

                ST_SHIFT: begin
                    r_cs_n <= 1'b1;
                    if (r_pf_wait) begin
                        r_prefetch <= mem.rdata;
                        r_pf_wait  <= 1'b0;
                    end
                    if (!r_cs_n) begin
                        r_pf_wait <= 1'b1;
                    end
                    if (w_tick) begin
                        case (r_phase)
                            2'd0: begin
                                r_phase <= 2'd1;
                                r_raw   <= w_cur_bit;
                            end
                            2'd1: begin
                                r_phase <= 2'd2;
                                r_raw   <= 1'b0;
                            end
                            default: begin
                                r_phase <= 2'd0;
                                if (r_bit_cnt != 3'd0) begin
                                    r_shift   <= w_shifted;
                                    r_bit_cnt <= r_bit_cnt - 3'd1;
                                    r_raw     <= 1'b1;
                                    // Entering the last bit of the byte: fetch the next one now.
                                    if (r_bit_cnt == 3'd1) begin
                                        if (w_final_byte) begin
                                            r_more <= 1'b0;
                                        end else begin
                                            r_more <= 1'b1;
                                            r_cs_n <= 1'b0;
                                            r_addr <= w_next_addr;
                                            if (r_addr == r_last) begin
                                                r_pass <= r_pass - 4'd1;
                                            end
                                        end
                                    end
                                end else if (r_more) begin
                                    r_shift   <= r_prefetch;
                                    r_bit_cnt <= 3'd7;
                                    r_raw     <= 1'b1;
                                end else begin
                                    r_raw       <= 1'b0;
                                    r_latch_cnt <= '0;
                                    r_state     <= ST_LATCH;
                                end
                            end
                        endcase
                    end
                end

                ST_LATCH: begin
                    r_raw <= 1'b0;
                    if (w_tick) begin
                        if (r_latch_cnt == LATCH_W'(RESET_TICKS - 1)) begin
                            r_progress <= 1'b0;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_latch_cnt <= r_latch_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign progress = r_progress;
    assign mem.cs_n = r_cs_n;
    assign mem.addr = r_addr;
    assign dout     = r_raw ^ polarity;

endmodule

// File: tb/tb_string_led_sequencer.sv
// Self-checking bench for string_led_sequencer.
// The reference model builds the tick schedule, the byte/address sequence and
// the read instants directly from the timing rules. It then predicts progress,
// cs_n, addr and dout for every cycle after start acceptance.
module tb_string_led_sequencer;

    localparam int ASIZE       = 32;
    localparam int PSIZE       = 32;
    localparam int RESET_TICKS = 80;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             controller_en = 1'b0;
    logic [PSIZE-1:0] prescaler = '0;
    logic             polarity = 1'b0;
    logic [3:0]       w_count = '0;
    logic [ASIZE-1:0] w_first = '0;
    logic [ASIZE-1:0] w_last = '0;
    logic             start = 1'b0;
    logic             progress;
    logic             dout;

    logic [7:0] sram [0:255];

    int n_vec = 0;
    int n_bad = 0;

    string_led_sequencer_if #(.ASIZE(ASIZE)) mem_if ();

    string_led_sequencer #(
        .ASIZE      (ASIZE),
        .PSIZE      (PSIZE),
        .RESET_TICKS(RESET_TICKS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .controller_en(controller_en),
        .prescaler    (prescaler),
        .polarity     (polarity),
        .w_count      (w_count),
        .w_first      (w_first),
        .w_last       (w_last),
        .start        (start),
        .progress     (progress),
        .mem          (mem_if),
        .dout         (dout)
    );

    always #5 clk = ~clk;

    // Synchronous-read SRAM: data appears the cycle after cs_n is sampled low.
    always @(posedge clk) begin
        if (!mem_if.cs_n) mem_if.rdata <= sram[mem_if.addr[7:0]];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_progress"}, progress, 1'b0);
        chk({tag, "_cs_n"}, mem_if.cs_n, 1'b1);
        chk({tag, "_dout"}, dout, polarity);
    endtask

    // One transfer. abort_c >= 0 drops controller_en in that cycle.
    // poke fires a stray start and scrambles the config while busy.
    task automatic run_xfer(input int p, input bit pol, input logic [ASIZE-1:0] first,
                            input logic [ASIZE-1:0] last, input int cnt,
                            input int abort_c, input bit poke);
        logic [ASIZE-1:0] seq[$];
        int               tt[$];
        int               rd_c[$];
        logic [ASIZE-1:0] span;
        int               len, nbytes, nbits, k, j, tend, b, ph;
        logic [7:0]       byte_v;
        bit               e_prog, e_cs, e_raw;
        logic [ASIZE-1:0] e_addr;

        @(negedge clk);
        prescaler     = PSIZE'(p);
        polarity      = pol;
        w_first       = first;
        w_last        = last;
        w_count       = 4'(cnt);
        controller_en = 1'b1;
        @(negedge clk);
        chk_idle("pre_idle");

        span   = last - first;
        len    = int'(span) + 1;
        nbytes = len * cnt;
        nbits  = 8 * nbytes;
        for (int ps = 0; ps < cnt; ps++)
            for (int a = 0; a < len; a++) seq.push_back(first + ASIZE'(a));

        // Edges (counted from acceptance) at which the line advances one phase.
        // Bit cells start in the cycle after the byte load, i.e. edge 2.
        tt.push_back(2);
        k = 3;
        while (tt.size() < 3 * nbits + RESET_TICKS + 1) begin
            if (k % (p + 1) == 0) tt.push_back(k);
            k++;
        end
        // The first read happens at acceptance. Each later read happens as
        // the previous byte enters its last bit.
        rd_c.push_back(0);
        for (int i = 1; i < nbytes; i++) rd_c.push_back(tt[3 * (8 * i - 1)]);

        tend = (abort_c >= 0) ? abort_c + 3 : tt[3 * nbits + RESET_TICKS] + 2;
        $display("xfer p=%0d pol=%0d first=%08h last=%08h cnt=%0d bytes=%0d abort=%0d poke=%0d",
                 p, pol, first, last, cnt, nbytes, abort_c, poke);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        j = -1;
        for (int c = 0; c <= tend; c++) begin
            while (j + 1 < tt.size() && tt[j + 1] <= c) j++;
            e_prog = (c < tt[3 * nbits + RESET_TICKS]);
            e_cs   = 1'b1;
            e_addr = '0;
            for (int i = 0; i < rd_c.size(); i++) begin
                if (rd_c[i] == c) begin
                    e_cs   = 1'b0;
                    e_addr = seq[i];
                end
            end
            e_raw = 1'b0;
            if (j >= 0 && j < 3 * nbits) begin
                b      = j / 3;
                ph     = j % 3;
                byte_v = sram[seq[b / 8][7:0]];
`ifdef STRING_LED_LSB_FIRST_EN
                e_raw = (ph == 0) ? 1'b1 : (ph == 1) ? byte_v[b % 8] : 1'b0;
`else
                e_raw = (ph == 0) ? 1'b1 : (ph == 1) ? byte_v[7 - (b % 8)] : 1'b0;
`endif
            end
            if (abort_c >= 0 && c > abort_c) begin
                e_prog = 1'b0;
                e_cs   = 1'b1;
                e_raw  = 1'b0;
            end
            chk("progress", progress, e_prog);
            chk("cs_n", mem_if.cs_n, e_cs);
            if (!e_cs) chk("addr", mem_if.addr, e_addr);
            chk("dout", dout, e_raw ^ pol);

            if (poke && c == 4) begin
                start   = 1'b1;
                w_first = ASIZE'($urandom);
                w_last  = ASIZE'($urandom);
                w_count = 4'($urandom_range(1, 15));
            end
            if (poke && c == 5) start = 1'b0;
            if (c == abort_c) controller_en = 1'b0;
            if (abort_c >= 0 && c == abort_c + 2) controller_en = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        controller_en = 1'b1;
    endtask

    // A start that must be ignored: no read, no line activity.
    task automatic ignored_start(input bit en, input logic [3:0] cnt);
        @(negedge clk);
        controller_en = en;
        w_count       = cnt;
        w_first       = 32'h0000_0010;
        w_last        = 32'h0000_0010;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        $display("ignored start en=%0d cnt=%0d", en, cnt);
        for (int c = 0; c < 4; c++) begin
            chk_idle("ignored");
            @(negedge clk);
        end
        controller_en = 1'b1;
    endtask

    task automatic async_reset_mid(input bit pol);
        @(negedge clk);
        prescaler = '0; polarity = pol; controller_en = 1'b1;
        w_first = 32'h0000_0010; w_last = 32'h0000_0011; w_count = 4'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("busy_before_reset", progress, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset mid-transfer pol=%0d", pol);
        chk("arst_progress", progress, 1'b0);
        chk("arst_cs_n", mem_if.cs_n, 1'b1);
        chk("arst_addr", mem_if.addr, '0);
        chk("arst_dout", dout, pol);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("post_reset");
    endtask

    initial begin
        int               p, len, cnt, abort_c;
        bit               pol, poke;
        logic [ASIZE-1:0] f;

        for (int a = 0; a < 256; a++) sram[a] = 8'h00;
        #12;
        chk("rst_progress", progress, 1'b0);
        chk("rst_cs_n", mem_if.cs_n, 1'b1);
        chk("rst_addr", mem_if.addr, '0);
        chk("rst_dout", dout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        sram[8'h10] = 8'hA5;
        run_xfer(0, 1'b0, 32'h10, 32'h10, 1, -1, 1'b0);
        run_xfer(0, 1'b1, 32'h10, 32'h10, 1, -1, 1'b0);

        sram[8'h00] = 8'h01; sram[8'h01] = 8'h80; sram[8'h02] = 8'hFF;
        run_xfer(3, 1'b0, 32'h0, 32'h2, 2, -1, 1'b0);

        sram[8'hFF] = 8'h3C; sram[8'h00] = 8'hC3; sram[8'h01] = 8'h5A;
        run_xfer(1, 1'b0, 32'hFFFF_FFFF, 32'h1, 1, -1, 1'b0);

        run_xfer(0, 1'b0, 32'h0, 32'h2, 1, 15, 1'b0);
        run_xfer(2, 1'b1, 32'h0, 32'h2, 1, -1, 1'b1);

        ignored_start(1'b1, 4'd0);
        ignored_start(1'b0, 4'd3);

        for (int t = 0; t < 8; t++) begin
            p       = $urandom_range(0, 3);
            pol     = 1'($urandom_range(0, 1));
            len     = $urandom_range(1, 4);
            cnt     = $urandom_range(1, 3);
            f       = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : ASIZE'($urandom);
            abort_c = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 60) : -1;
            poke    = 1'($urandom_range(0, 1));
            for (int a = 0; a < 256; a++) sram[a] = 8'($urandom);
            run_xfer(p, pol, f, f + ASIZE'(len - 1), cnt, abort_c, poke);
        end

        async_reset_mid(1'b1);
        run_xfer(0, 1'b0, 32'h20, 32'h21, 1, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
